pwm_duty_meter: RTL and testbench
=================================

# pwm_duty_meter

- Measures an incoming PWM waveform: high time and period in `clk` cycles, plus duty cycle in integer percent.
- It is the receive-side counterpart to the LED PWM generators: 100-step duty, percent scale.
- Used on the board to read back generated PWM, or an external PWM source, for display and self-check.
- Results are reported once per completed period with a one-cycle `valid` strobe; stuck-high and stuck-low inputs are flagged by timeout.

## Interface
- `CNT_W`, 16: width of the high/period counters.
- `TIMEOUT`, 1000: cycles without a `pwm_in` edge before declaring stuck. Must be < 2^CNT_W − 1.
- `FILT_LEN`, 4: glitch-filter stability length. Used only with the filter macro.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: measurement enable. Low forces SYNC and suppresses `valid`.
- `pwm_in` in 1: asynchronous PWM input.
- `high_cnt` out CNT_W: high cycles of the last measured period.
- `period_cnt` out CNT_W: total cycles of the last measured period.
- `duty_pct` out 7: floor(high_cnt*100/period_cnt), range 0..100.
- `valid` out 1: one-cycle strobe when the outputs update.
- `stuck_hi` out 1: input held high ≥ TIMEOUT cycles.
- `stuck_lo` out 1: input held low ≥ TIMEOUT cycles.
- `overrun` out 1: sticky; a period completed while the divider was busy. Cleared only by `rst`.

## Operation
- Input path: `pwm_in` → 2-flop synchronizer → (optional filter) → `s`.
  - `rise = s & ~s_d`; `fall = ~s & s_d`.
- FSM states: SYNC, HIGH, LOW.
  - SYNC: counters cleared; on `rise` → HIGH with `hcnt`=1, `pcnt`=1.
  - HIGH: `hcnt`++, `pcnt`++ each cycle; on `fall` → LOW (`pcnt`++).
  - LOW: `pcnt`++ each cycle; on `rise`:
    - If the divider is idle: latch `high_cnt`=`hcnt`, `period_cnt`=`pcnt` and start the divider.
    - If the divider is busy: set `overrun` and drop this period.
    - In both cases restart `hcnt`=1, `pcnt`=1 and go to HIGH.
- Timeout: an idle counter resets on every `rise`/`fall` and counts otherwise. On reaching TIMEOUT:
  - Set `stuck_hi` (if `s`=1) or `stuck_lo` (if `s`=0).
  - Force `high_cnt`=`period_cnt`=0 and `duty_pct`=100 (stuck high) or 0 (stuck low).
  - Pulse `valid` once, then go to SYNC.
  - The stuck flag clears on the next edge of `s`.
- Counters saturate at 2^CNT_W − 1. The timeout always fires first for a legal TIMEOUT.
- Divider:
  - Restoring, 7 iterations: numerator `high_cnt*100` (CNT_W+7 bits), divisor `period_cnt`.
  - The quotient is ≤100, so 7 bits suffice.
  - `period_cnt` ≥ 2 by construction, so there is no divide-by-zero.
- Simultaneous events:
  - A timeout and a `rise` in the same cycle: the `rise` wins and the idle counter resets.
  - A divider result and a timeout `valid` in the same cycle: the timeout result wins and the divider result is discarded.
- `en` low: FSM → SYNC, divider aborted, `valid` suppressed. Outputs hold their last values.
- Reset mid-operation: everything returns to reset values immediately. The first result comes only after a full period following a fresh `rise`.

## Timing
- Reset values: `high_cnt`=0, `period_cnt`=0, `duty_pct`=0, `valid`=0, `stuck_hi`=0, `stuck_lo`=0, `overrun`=0. FSM starts in SYNC.
- Latency without the filter, for the `pwm_in` 0→1 that closes a period:
  - Synchronizer: 2 cycles.
  - Latch/start: 1 cycle.
  - Divide: 7 cycles.
  - `valid` is high in the cycle after the divide completes (9–10 cycles, depending on sampling phase).
  - `high_cnt`/`period_cnt` update at latch time; `duty_pct` updates together with `valid`.
- Measured values are exact in synchronized cycles: a stable input of period P and high time H gives `period_cnt`=P and `high_cnt`=H.
- Minimum measurable pulse is 1 cycle high / 1 cycle low without the filter.
- Back-to-back results are possible only when period ≥ 8 cycles; shorter periods set `overrun`.

## Configuration
- `PWM_METER_GLITCH_FILTER_EN` defined:
  - `s` changes only after the synchronized input has been stable for FILT_LEN consecutive cycles.
  - This adds FILT_LEN cycles of latency.
  - Pulses shorter than FILT_LEN are ignored.
- Undefined: `s` is the synchronizer output directly. FILT_LEN is unused.

## Structure
- Package `pwm_pkg`: FSM state enum (SYNC/HIGH/LOW), `PCT_W`=7, `PCT_SCALE`=100, `DIV_STEPS`=7.
- Sub-module `pwm_pct_div`:
  - Inputs: start, numerator, divisor.
  - Outputs: busy, done (one cycle), quotient[6:0].
  - Parameterized by CNT_W.
- Top holds the synchronizer, optional filter, FSM, counters, timeout and flags.

## Test plan
- Period 100, high 30, repeated 5 times → each `valid` gives `high_cnt`=30, `period_cnt`=100, `duty_pct`=30; `overrun`=0.
- High 1, low 2 (period 3) → `overrun` set after the second period; first result `duty_pct`=33.
- `pwm_in` held high 1200 cycles with TIMEOUT=1000 → one `valid`, `stuck_hi`=1, `duty_pct`=100, `high_cnt`=0; next edge clears `stuck_hi`.
- `pwm_in` held low 1200 cycles → one `valid`, `stuck_lo`=1, `duty_pct`=0.
- `rst` asserted mid-HIGH → all outputs 0 next cycle; after release, the first `valid` comes only after one complete new period.
- With `PWM_METER_GLITCH_FILTER_EN`, FILT_LEN=4, a 2-cycle glitch inside the high phase of a 100/50 waveform → `high_cnt`=50 unaffected. Without the macro → the glitch causes an extra short period measurement.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty meter.
package pwm_pkg;

   typedef enum logic [1:0] {
      SYNC = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam int PCT_W     = 7;
   localparam int PCT_SCALE = 100;
   localparam int DIV_STEPS = 7;

endpackage

// File: rtl/pwm_pct_div.sv
// Restoring divider for the duty percentage: quotient < 128, so only 7 quotient bits are produced.
// Latency: load on start, 7 iteration cycles, done pulses with the final quotient.
// Backpressure: none; start is ignored while busy, abort returns it to idle at once.
module pwm_pct_div
   import pwm_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   abort,
   input  logic                   start,
   input  logic [CNT_W+PCT_W-1:0] num,
   input  logic [CNT_W-1:0]       den,
   output logic                   busy,
   output logic                   done,
   output logic [PCT_W-1:0]       quotient
);

   localparam int NW = CNT_W + PCT_W;
   localparam int SW = $clog2(DIV_STEPS);

   logic [NW-1:0] rem;
   logic [NW-1:0] dsh;
   logic [SW-1:0] step;
   logic          ge;

   assign ge = (rem >= dsh);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem      <= '0;
         dsh      <= '0;
         step     <= '0;
         quotient <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            busy <= 1'b0;
         end else if (start && !busy) begin
            // Divisor pre-shifted to the weight of the top quotient bit.
            rem      <= num;
            dsh      <= NW'(den) << (DIV_STEPS - 1);
            step     <= '0;
            quotient <= '0;
            busy     <= 1'b1;
         end else if (busy) begin
            rem      <= ge ? (rem - dsh) : rem;
            quotient <= {quotient[PCT_W-2:0], ge};
            dsh      <= dsh >> 1;
            step     <= step + 1'b1;
            if (step == SW'(DIV_STEPS - 1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM high-time/period/duty meter with stuck detection; optional glitch filter via PWM_METER_GLITCH_FILTER_EN.
// Latency: about 10 cycles from the closing pwm_in rise to valid (plus FILT_LEN with the filter).
// Backpressure: none; a period closing while the divider is busy is dropped and flagged in overrun.
module pwm_duty_meter
   import pwm_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int TIMEOUT  = 1000,
   parameter int FILT_LEN = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic [PCT_W-1:0] duty_pct,
   output logic             valid,
   output logic             stuck_hi,
   output logic             stuck_lo,
   output logic             overrun
);

   localparam int TW = $clog2(TIMEOUT + 1);

   if (TIMEOUT < 2 || TIMEOUT >= (2 ** CNT_W) - 1 || FILT_LEN < 1) begin : g_param_check
      $error("pwm_duty_meter: illegal TIMEOUT/FILT_LEN for CNT_W");
   end

   logic             sync1, sync2, s, s_d;
   logic             rise, fall, edge_s, tmo;
   logic [TW-1:0]    idle;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] hcnt, pcnt;
   logic             latch, div_start, div_drop;
   logic             div_busy, div_done;
   logic [PCT_W-1:0] div_q;
   logic [CNT_W+PCT_W-1:0] div_num;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= pwm_in;
         sync2 <= sync1;
      end
   end

`ifdef PWM_METER_GLITCH_FILTER_EN
   localparam int FW = $clog2(FILT_LEN + 1);
   logic [FW-1:0] filt_cnt;

   // s follows sync2 only after FILT_LEN consecutive cycles of disagreement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s        <= 1'b0;
         filt_cnt <= '0;
      end else if (sync2 == s) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
         s        <= sync2;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + 1'b1;
      end
   end
`else
   assign s = sync2;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) s_d <= 1'b0;
      else     s_d <= s;
   end

   assign rise   = s & ~s_d;
   assign fall   = ~s & s_d;
   assign edge_s = rise | fall;

   // idle counts cycles the level has been held; saturates at TIMEOUT so it fires once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      idle <= '0;
      else if (!en)                 idle <= '0;
      else if (edge_s)              idle <= TW'(1);
      else if (idle != TW'(TIMEOUT)) idle <= idle + 1'b1;
   end

   assign tmo = en & ~edge_s & (idle == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= SYNC;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!en || tmo) begin
         state_d = SYNC;
      end else begin
         case (state_q)
            SYNC:    if (rise) state_d = HIGH;
            HIGH:    if (fall) state_d = LOW;
            LOW:     if (rise) state_d = HIGH;
            default: state_d = SYNC;
         endcase
      end
   end

   always_comb begin
      latch     = en && (state_q == LOW) && rise;
      div_start = latch && !div_busy;
      div_drop  = latch && div_busy;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcnt <= '0;
         pcnt <= '0;
      end else if (!en || tmo) begin
         hcnt <= '0;
         pcnt <= '0;
      end else begin
         case (state_q)
            HIGH: begin
               pcnt <= sat_inc(pcnt);
               if (!fall) hcnt <= sat_inc(hcnt);
            end
            SYNC, LOW: begin
               if (rise) begin
                  hcnt <= CNT_W'(1);
                  pcnt <= CNT_W'(1);
               end else if (state_q == LOW) begin
                  pcnt <= sat_inc(pcnt);
               end else begin
                  hcnt <= '0;
                  pcnt <= '0;
               end
            end
            default: begin
               hcnt <= '0;
               pcnt <= '0;
            end
         endcase
      end
   end

   assign div_num = (CNT_W+PCT_W)'(hcnt) * (CNT_W+PCT_W)'(PCT_SCALE);

   pwm_pct_div #(.CNT_W(CNT_W)) u_div (
      .clk      (clk),
      .rst      (rst),
      .abort    (!en || tmo),
      .start    (div_start),
      .num      (div_num),
      .den      (pcnt),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_q)
   );

   // A timeout result takes priority over a divider result landing in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         high_cnt   <= '0;
         period_cnt <= '0;
         duty_pct   <= '0;
         valid      <= 1'b0;
         stuck_hi   <= 1'b0;
         stuck_lo   <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (tmo) begin
            stuck_hi   <= s;
            stuck_lo   <= ~s;
            high_cnt   <= '0;
            period_cnt <= '0;
            duty_pct   <= s ? PCT_W'(PCT_SCALE) : '0;
            valid      <= 1'b1;
         end else begin
            if (edge_s) begin
               stuck_hi <= 1'b0;
               stuck_lo <= 1'b0;
            end
            if (div_start) begin
               high_cnt   <= hcnt;
               period_cnt <= pcnt;
            end
            if (div_done && en) begin
               duty_pct <= div_q;
               valid    <= 1'b1;
            end
         end
         if (div_drop) overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Scoreboarded bench for pwm_duty_meter: segment-level PWM model feeds expected results, monitor checks each valid.
module tb_pwm_duty_meter;

   localparam int CNT_W    = 16;
   localparam int TIMEOUT  = 1000;
   localparam int FILT_LEN = 4;
`ifdef PWM_METER_GLITCH_FILTER_EN
   localparam int MINSEG = FILT_LEN;
`else
   localparam int MINSEG = 1;
`endif

   logic             clk = 1'b0;
   logic             rst, en, pwm_in;
   logic [CNT_W-1:0] high_cnt, period_cnt;
   logic [6:0]       duty_pct;
   logic             valid, stuck_hi, stuck_lo, overrun;

   pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .FILT_LEN(FILT_LEN)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .pwm_in     (pwm_in),
      .high_cnt   (high_cnt),
      .period_cnt (period_cnt),
      .duty_pct   (duty_pct),
      .valid      (valid),
      .stuck_hi   (stuck_hi),
      .stuck_lo   (stuck_lo),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int h;
      int p;
      int d;
      int shi;
      int slo;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   failures = 0;
   int   now = 0;
   int   exp_ovr = 0;
   int   fresh = 1;
   int   last_rise = 0;
   int   high_len = 0;
   int   last_acc = -1000;

   always @(posedge clk) now <= now + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, now);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model: a segment is `len` cycles at `level`, beginning with an edge when level is 1
   // or follows a high segment. Results come from rise-to-rise periods; the divider stays occupied
   // for 8 cycles after an accepted period, so a closing rise sooner than that is an overrun.
   task automatic model_seg(input int level, input int len);
      int per;
      if (level != 0) begin
         if (fresh == 0) begin
            per = now - last_rise;
            if (now - last_acc >= 8) begin
               sbq.push_back('{h: high_len, p: per, d: (high_len * 100) / per, shi: 0, slo: 0});
               last_acc = now;
            end else begin
               exp_ovr = 1;
            end
         end
         fresh     = 0;
         last_rise = now;
         high_len  = len;
      end
      if (len >= TIMEOUT) begin
         sbq.push_back('{h: 0, p: 0, d: (level != 0) ? 100 : 0, shi: level, slo: (level != 0) ? 0 : 1});
         fresh = 1;
      end
   endtask

   task automatic drive_seg(input int level, input int len);
      model_seg(level, len);
      pwm_in = level[0];
      cyc(len);
   endtask

   task automatic restart_model();
      fresh    = 1;
      last_acc = -1000;
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst && valid) begin
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid: got valid with hc=%0d pc=%0d duty=%0d, required no pending result",
                     high_cnt, period_cnt, duty_pct);
         end else begin
            e = sbq.pop_front();
            check("high_cnt", int'(high_cnt), e.h);
            check("period_cnt", int'(period_cnt), e.p);
            check("duty_pct", int'(duty_pct), e.d);
            check("stuck_hi", int'(stuck_hi), e.shi);
            check("stuck_lo", int'(stuck_lo), e.slo);
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_high_cnt"}, int'(high_cnt), 0);
      check({tag, "_period_cnt"}, int'(period_cnt), 0);
      check({tag, "_duty_pct"}, int'(duty_pct), 0);
      check({tag, "_valid"}, int'(valid), 0);
      check({tag, "_stuck_hi"}, int'(stuck_hi), 0);
      check({tag, "_stuck_lo"}, int'(stuck_lo), 0);
      check({tag, "_overrun"}, int'(overrun), 0);
   endtask

   initial begin
      rst    = 1'b1;
      en     = 1'b1;
      pwm_in = 1'b0;
      cyc(3);
      check_all_zero("reset");
      rst = 1'b0;
      restart_model();

      // 100-cycle period, 30 high, five results.
      drive_seg(0, 20);
      repeat (5) begin
         drive_seg(1, 30);
         drive_seg(0, 70);
      end
      drive_seg(1, 30);
      drive_seg(0, 40);
      check("overrun_after_100_30", int'(overrun), exp_ovr);

      // Stuck high, then stuck low; each flag clears on the next edge.
      drive_seg(1, 1200);
      check("stuck_hi_held", int'(stuck_hi), 1);
      model_seg(0, 1200);
      pwm_in = 1'b0;
      cyc(5);
      check("stuck_hi_cleared", int'(stuck_hi), 0);
      cyc(1195);
      check("stuck_lo_held", int'(stuck_lo), 1);
      model_seg(1, 40);
      pwm_in = 1'b1;
      cyc(5);
      check("stuck_lo_cleared", int'(stuck_lo), 0);
      cyc(35);
      drive_seg(0, 40);

      // Random waveform, with occasional short segments that can cause overruns.
      repeat (30) begin
         drive_seg(1, ($urandom_range(0, 3) == 0) ? $urandom_range(MINSEG, MINSEG + 4) : $urandom_range(MINSEG, 120));
         drive_seg(0, ($urandom_range(0, 3) == 0) ? $urandom_range(MINSEG, MINSEG + 4) : $urandom_range(MINSEG, 120));
      end
      cyc(30);
      check("overrun_after_random", int'(overrun), exp_ovr);

      // Enable low: pulses during the gap must produce nothing; measurement restarts afterwards.
      en = 1'b0;
      pwm_in = 1'b1; cyc(5);
      pwm_in = 1'b0; cyc(5);
      pwm_in = 1'b1; cyc(5);
      pwm_in = 1'b0; cyc(15);
      en = 1'b1;
      restart_model();
      cyc(10);

      // 100/50 waveform with a 2-cycle low glitch inside the high phase.
      drive_seg(1, 20);
      drive_seg(0, 50);
`ifdef PWM_METER_GLITCH_FILTER_EN
      model_seg(1, 50);
      pwm_in = 1'b1; cyc(24);
      pwm_in = 1'b0; cyc(2);
      pwm_in = 1'b1; cyc(24);
`else
      drive_seg(1, 24);
      drive_seg(0, 2);
      drive_seg(1, 24);
`endif
      drive_seg(0, 50);
      drive_seg(1, 20);
      drive_seg(0, 30);

      // Reset asserted in the middle of a high phase.
      model_seg(1, 20);
      pwm_in = 1'b1;
      cyc(20);
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      check("midrst_pending", sbq.size(), 0);
      sbq.delete();
      pwm_in = 1'b0;
      cyc(5);
      rst = 1'b0;
      restart_model();
      exp_ovr = 0;
      cyc(10);

      // Period 8 is the shortest that still allows back-to-back results.
      repeat (5) begin
         drive_seg(1, 4);
         drive_seg(0, 4);
      end
      drive_seg(1, 4);
      drive_seg(0, 30);
      check("overrun_period8", int'(overrun), exp_ovr);

`ifndef PWM_METER_GLITCH_FILTER_EN
      // 1 high / 2 low: first result 33%, later periods overrun.
      repeat (6) begin
         drive_seg(1, 1);
         drive_seg(0, 2);
      end
      drive_seg(1, 1);
      drive_seg(0, 30);
      check("overrun_period3", int'(overrun), exp_ovr);
`endif

      cyc(30);
      check("scoreboard_drained", sbq.size(), 0);
      check("overrun_final", int'(overrun), exp_ovr);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
